alu_md_control: RTL and testbench
=================================

// Module: alu_md_control
// PURPOSE
//  EX-stage ALU control, successor generation. Decodes ALUOp/funct into a
//  CTRL_W-bit ALU opcode (superset of the 3-bit set) and owns a multi-cycle
//  multiply/divide sequencer with HI/LO registers. Raises stall_o to freeze
//  IF/ID/EX while a HI/LO consumer or a second MD op meets a busy sequencer.
// PARAMETERS
//  WIDTH   32  operand / HI / LO width
//  CTRL_W  4   ALU control output width (>=4)
// PORTS
//  clk         in   1       clock, rising edge
//  rst_n       in   1       asynchronous reset, active-low
//  valid_i     in   1       EX instruction valid
//  flush_i     in   1       EX flush; aborts MD op
//  alu_op_i    in   2       from main control: 00 add, 01 sub, 10 R-type, 11 or
//  funct_i     in   6       instruction funct field
//  rs_i        in   WIDTH   operand A (dividend / multiplicand)
//  rt_i        in   WIDTH   operand B (divisor / multiplier)
//  alu_ctrl_o  out  CTRL_W  ALU opcode
//  hi_o        out  WIDTH   HI register
//  lo_o        out  WIDTH   LO register
//  md_busy_o   out  1       sequencer active
//  stall_o     out  1       pipeline stall request
// BEHAVIOUR
//  - One clock; reset asynchronous, active-low. Reset: state IDLE, hi_o=lo_o=0,
//    md_busy_o=0, stall_o=0; alu_ctrl_o forced NOP (1111) while rst_n=0.
//  - alu_ctrl_o combinational. valid_i=0 -> NOP. alu_op 00 ADD(0010), 01 SUB(0110),
//    11 OR(0001). 10: 100000 ADD, 100010 SUB, 100100 AND(0000), 100101 OR,
//    100110 XOR(0100), 100111 NOR(1100), 101010 SLT(0111), 000000 SLL(0011),
//    000010 SRL(0101), 010000 mfhi PASS_HI(1000), 010010 mflo PASS_LO(1001);
//    mult/div/mthi/mtlo and undefined funct -> NOP. No latches.
//  - MD ops (alu_op 10): 011000 mult, 011001 multu, 011010 div, 011011 divu,
//    010001 mthi, 010011 mtlo.
//  - stall_o = valid_i & busy & funct in {MD ops, mfhi, mflo}. Combinational.
//  - Accept: valid_i & ~flush_i & ~stall_o & mult/div at edge E0. Latch |A|,|B|,
//    result sign (signed ops only), go MUL or DIV; md_busy_o=1 after E0.
//  - MUL: shift-add, 1 bit/cycle, WIDTH cycles. DIV: restoring, 1 bit/cycle,
//    WIDTH cycles. Iteration counter counts 0..WIDTH-1, wraps to 0 in FIX.
//  - FIX: one cycle, sign correction; HI/LO written at edge E0+WIDTH+1; IDLE,
//    md_busy_o=0 after that same edge. Back-to-back op accepted next cycle.
//  - Signs: product negated if signs differ; quotient negated if signs differ,
//    remainder takes dividend sign.
//  - Divide by zero: LO=all ones, HI=dividend (signed and unsigned).
//  - Signed MIN/-1: LO=MIN, HI=0 (no trap).
//  - mthi/mtlo: write HI/LO at edge when valid_i & ~flush_i & ~busy.
//  - flush_i while busy: abort at next edge -> IDLE, HI/LO unchanged. flush_i
//    and accept in same cycle: flush wins, nothing starts.
//  - rst_n low mid-operation: immediate abort, all state to reset values.
// STRUCTURE
//  - alu_pkg: ALUOp constants, funct constants, CTRL_W opcode constants
//    (NOP=1111), MD state enum {IDLE, MUL, DIV, FIX}.
//  - Sub-module md_seq_core: datapath (accumulator, shift regs, counter,
//    sign fixup); top holds decode, stall logic, HI/LO write arbitration.
// TESTING (WIDTH=32)
//  - rst_n low mid-DIV cycle 12 -> md_busy_o=0, hi_o=lo_o=0, alu_ctrl_o=1111.
//  - alu_op 10/funct 100010 -> 0110; alu_op 11 -> 0001; valid_i=0 -> 1111;
//    funct 111111 -> 1111.
//  - mult rs=FFFFFFFD (-3), rt=7 -> busy 33 cycles, then HI=FFFFFFFF,
//    LO=FFFFFFEB; multu same operands -> HI=00000006, LO=FFFFFFEB.
//  - div -7/2 -> LO=FFFFFFFD, HI=FFFFFFFF; divu 7/0 -> LO=FFFFFFFF,
//    HI=00000007; div 80000000/FFFFFFFF -> LO=80000000, HI=0.
//  - mflo issued 5 cycles into mult -> stall_o=1 until busy drops, then
//    alu_ctrl_o=1001 and lo_o holds the new product.
//  - flush_i at cycle 10 of mult, HI/LO preset 1234/5678 via mthi/mtlo ->
//    busy=0 next cycle, HI/LO still 1234/5678; flush+accept same cycle -> no start.

Source files
------------

// File: rtl/alu_pkg.sv
//------------------------------------------------------------------------------
// Module : alu_pkg
// Brief  : ALUOp/funct encodings, ALU opcodes and MD sequencer state type.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package alu_pkg;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_OR    = 2'b11;

  localparam logic [5:0] FN_SLL   = 6'b000000;
  localparam logic [5:0] FN_SRL   = 6'b000010;
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MTHI  = 6'b010001;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_MTLO  = 6'b010011;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_XOR   = 6'b100110;
  localparam logic [5:0] FN_NOR   = 6'b100111;
  localparam logic [5:0] FN_SLT   = 6'b101010;

  localparam logic [3:0] OP_AND     = 4'b0000;
  localparam logic [3:0] OP_OR      = 4'b0001;
  localparam logic [3:0] OP_ADD     = 4'b0010;
  localparam logic [3:0] OP_SLL     = 4'b0011;
  localparam logic [3:0] OP_XOR     = 4'b0100;
  localparam logic [3:0] OP_SRL     = 4'b0101;
  localparam logic [3:0] OP_SUB     = 4'b0110;
  localparam logic [3:0] OP_SLT     = 4'b0111;
  localparam logic [3:0] OP_PASS_HI = 4'b1000;
  localparam logic [3:0] OP_PASS_LO = 4'b1001;
  localparam logic [3:0] OP_NOR     = 4'b1100;
  localparam logic [3:0] OP_NOP     = 4'b1111;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_MUL  = 2'd1,
    MD_DIV  = 2'd2,
    MD_FIX  = 2'd3
  } md_state_e;

  function automatic logic is_muldiv(input logic [5:0] f);
    return (f == FN_MULT) || (f == FN_MULTU) || (f == FN_DIV) || (f == FN_DIVU);
  endfunction

  // Any funct that reads or writes HI/LO and therefore must wait for the sequencer.
  function automatic logic is_hilo_user(input logic [5:0] f);
    return is_muldiv(f) || (f == FN_MTHI) || (f == FN_MTLO) ||
           (f == FN_MFHI) || (f == FN_MFLO);
  endfunction

endpackage

`default_nettype wire

// File: rtl/md_seq_core.sv
//------------------------------------------------------------------------------
// Module : md_seq_core
// Brief  : Iterative multiply/divide datapath (shift-add / restoring) with sign fixup.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module md_seq_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic             i_is_div,
  input  logic             i_is_signed,
  input  logic             i_abort,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  localparam int             CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  md_state_e          r_state;
  md_state_e          w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]   r_low;
  logic [WIDTH-1:0]   r_opnd;
  logic [WIDTH-1:0]   r_dividend;
  logic               r_neg_q;
  logic               r_neg_r;
  logic               r_div_zero;

  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_shift;
  logic [WIDTH:0]     w_trial;
  logic [2*WIDTH-1:0] w_raw;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;

  assign w_a_mag = (i_is_signed && i_a[WIDTH-1]) ? -i_a : i_a;
  assign w_b_mag = (i_is_signed && i_b[WIDTH-1]) ? -i_b : i_b;

  // r_opnd holds the multiplicand or divisor; {r_acc, r_low} is product or {remainder, quotient}.
  assign w_sum   = {1'b0, r_acc} + (r_low[0] ? {1'b0, r_opnd} : '0);
  assign w_shift = {r_acc, r_low[WIDTH-1]};
  assign w_trial = w_shift - {1'b0, r_opnd};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= MD_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      MD_IDLE: if (i_start) w_state_nxt = i_is_div ? MD_DIV : MD_MUL;
      MD_MUL,
      MD_DIV:  if (i_abort) w_state_nxt = MD_IDLE;
               else if (r_cnt == LAST) w_state_nxt = MD_FIX;
      MD_FIX:  w_state_nxt = MD_IDLE;
      default: w_state_nxt = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_acc      <= '0;
      r_low      <= '0;
      r_opnd     <= '0;
      r_dividend <= '0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_div_zero <= 1'b0;
    end else if (r_state == MD_IDLE && i_start) begin
      r_cnt      <= '0;
      r_acc      <= '0;
      r_opnd     <= i_is_div ? w_b_mag : w_a_mag;
      r_low      <= i_is_div ? w_a_mag : w_b_mag;
      r_dividend <= i_a;
      r_neg_q    <= i_is_signed & (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
      r_neg_r    <= i_is_signed & i_a[WIDTH-1];
      r_div_zero <= (i_b == '0);
    end else if (r_state == MD_MUL) begin
      r_cnt          <= (r_cnt == LAST) ? '0 : r_cnt + CNT_W'(1);
      {r_acc, r_low} <= {w_sum, r_low[WIDTH-1:1]};
    end else if (r_state == MD_DIV) begin
      r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + CNT_W'(1);
      r_acc <= w_trial[WIDTH] ? w_shift[WIDTH-1:0] : w_trial[WIDTH-1:0];
      r_low <= {r_low[WIDTH-2:0], ~w_trial[WIDTH]};
    end
  end

  assign w_raw  = {r_acc, r_low};
  assign w_prod = r_neg_q ? -w_raw : w_raw;
  assign w_quo  = r_neg_q ? -r_low : r_low;
  assign w_rem  = r_neg_r ? -r_acc : r_acc;

  // Result is only meaningful in FIX; the DIV/MUL distinction is recovered from the prior state.
  logic r_was_div;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    r_was_div <= 1'b0;
    else if (r_state == MD_MUL)    r_was_div <= 1'b0;
    else if (r_state == MD_DIV)    r_was_div <= 1'b1;
  end

  always_comb begin
    o_busy = (r_state != MD_IDLE);
    o_done = (r_state == MD_FIX);
    o_hi   = w_prod[2*WIDTH-1:WIDTH];
    o_lo   = w_prod[WIDTH-1:0];
    if (r_was_div) begin
      if (r_div_zero) begin
        o_hi = r_dividend;
        o_lo = '1;
      end else begin
        o_hi = w_rem;
        o_lo = w_quo;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/alu_md_control.sv
//------------------------------------------------------------------------------
// Module : alu_md_control
// Brief  : EX-stage ALU control decode, HI/LO registers and MD stall generation.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module alu_md_control
  import alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_i,
  input  logic              flush_i,
  input  logic [1:0]        alu_op_i,
  input  logic [5:0]        funct_i,
  input  logic [WIDTH-1:0]  rs_i,
  input  logic [WIDTH-1:0]  rt_i,
  output logic [CTRL_W-1:0] alu_ctrl_o,
  output logic [WIDTH-1:0]  hi_o,
  output logic [WIDTH-1:0]  lo_o,
  output logic              md_busy_o,
  output logic              stall_o
);

  logic [3:0]       w_op;
  logic             w_rtype;
  logic             w_busy;
  logic             w_done;
  logic             w_accept;
  logic [WIDTH-1:0] w_hi_res;
  logic [WIDTH-1:0] w_lo_res;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  always_comb begin
    w_op = OP_NOP;
    if (rst_n && valid_i) begin
      case (alu_op_i)
        ALUOP_ADD: w_op = OP_ADD;
        ALUOP_SUB: w_op = OP_SUB;
        ALUOP_OR:  w_op = OP_OR;
        default: begin
          case (funct_i)
            FN_ADD:  w_op = OP_ADD;
            FN_SUB:  w_op = OP_SUB;
            FN_AND:  w_op = OP_AND;
            FN_OR:   w_op = OP_OR;
            FN_XOR:  w_op = OP_XOR;
            FN_NOR:  w_op = OP_NOR;
            FN_SLT:  w_op = OP_SLT;
            FN_SLL:  w_op = OP_SLL;
            FN_SRL:  w_op = OP_SRL;
            FN_MFHI: w_op = OP_PASS_HI;
            FN_MFLO: w_op = OP_PASS_LO;
            default: w_op = OP_NOP;
          endcase
        end
      endcase
    end
  end

  assign alu_ctrl_o = CTRL_W'(w_op);

  assign w_rtype  = (alu_op_i == ALUOP_RTYPE);
  assign stall_o  = valid_i & w_busy & w_rtype & is_hilo_user(funct_i);
  assign w_accept = valid_i & ~flush_i & ~stall_o & w_rtype & is_muldiv(funct_i);

  md_seq_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_start     (w_accept),
    .i_is_div    (funct_i[1]),
    .i_is_signed (~funct_i[0]),
    .i_abort     (flush_i),
    .i_a         (rs_i),
    .i_b         (rt_i),
    .o_busy      (w_busy),
    .o_done      (w_done),
    .o_hi        (w_hi_res),
    .o_lo        (w_lo_res)
  );

  // A flush landing on the FIX cycle still discards the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_done && !flush_i) begin
      r_hi <= w_hi_res;
      r_lo <= w_lo_res;
    end else if (valid_i && !flush_i && !w_busy && w_rtype) begin
      if (funct_i == FN_MTHI) r_hi <= rs_i;
      if (funct_i == FN_MTLO) r_lo <= rs_i;
    end
  end

  assign hi_o      = r_hi;
  assign lo_o      = r_lo;
  assign md_busy_o = w_busy;

endmodule

`default_nettype wire

// File: tb/tb_alu_md_control.sv
//------------------------------------------------------------------------------
// Module : tb_alu_md_control
// Brief  : Directed self-checking bench with an expected-result queue for MD ops.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_alu_md_control;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         valid_i = 1'b0;
  logic         flush_i = 1'b0;
  logic [1:0]   alu_op_i = 2'b00;
  logic [5:0]   funct_i = 6'b0;
  logic [W-1:0] rs_i = '0;
  logic [W-1:0] rt_i = '0;
  logic [3:0]   alu_ctrl_o;
  logic [W-1:0] hi_o;
  logic [W-1:0] lo_o;
  logic         md_busy_o;
  logic         stall_o;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    string       tag;
    logic [63:0] hilo;
  } exp_t;
  exp_t sb[$];

  // {valid, alu_op, funct, expected opcode}
  logic [12:0] dec_tbl [18] = '{
    13'b1_00_000000_0010, 13'b1_01_000000_0110, 13'b1_11_000000_0001,
    13'b0_10_100000_1111, 13'b1_10_100000_0010, 13'b1_10_100010_0110,
    13'b1_10_100100_0000, 13'b1_10_100101_0001, 13'b1_10_100110_0100,
    13'b1_10_100111_1100, 13'b1_10_101010_0111, 13'b1_10_000000_0011,
    13'b1_10_000010_0101, 13'b1_10_010000_1000, 13'b1_10_010010_1001,
    13'b1_10_011000_1111, 13'b1_10_010001_1111, 13'b1_10_111111_1111
  };

  always #5 clk = ~clk;

  alu_md_control #(
    .WIDTH  (W),
    .CTRL_W (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .valid_i    (valid_i),
    .flush_i    (flush_i),
    .alu_op_i   (alu_op_i),
    .funct_i    (funct_i),
    .rs_i       (rs_i),
    .rt_i       (rt_i),
    .alu_ctrl_o (alu_ctrl_o),
    .hi_o       (hi_o),
    .lo_o       (lo_o),
    .md_busy_o  (md_busy_o),
    .stall_o    (stall_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns just after the accepting edge.
  task automatic issue(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    valid_i  = 1'b1;
    alu_op_i = 2'b10;
    funct_i  = f;
    rs_i     = a;
    rt_i     = b;
    tick();
    valid_i  = 1'b0;
  endtask

  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (md_busy_o === 1'b1 && cyc < 200) begin
      tick();
      cyc++;
    end
  endtask

  task automatic run_md(input string tag, input logic [5:0] f, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [63:0] hilo);
    exp_t e;
    int   cyc;
    e.tag  = tag;
    e.hilo = hilo;
    sb.push_back(e);
    issue(f, a, b);
    chk({tag, "_busy"}, 64'(md_busy_o), 64'd1);
    wait_idle(cyc);
    chk({tag, "_cycles"}, 64'(cyc), 64'd33);
    e = sb.pop_front();
    chk({e.tag, "_hi"}, 64'(hi_o), 64'(e.hilo[63:32]));
    chk({e.tag, "_lo"}, 64'(lo_o), 64'(e.hilo[31:0]));
  endtask

  function automatic logic [63:0] md_model(input logic [5:0] f, input logic [31:0] a,
                                           input logic [31:0] b);
    logic signed [63:0] sa;
    logic signed [63:0] sb64;
    logic signed [31:0] qa;
    logic signed [31:0] qb;
    logic [63:0]        r;
    sa   = {{32{a[31]}}, a};
    sb64 = {{32{b[31]}}, b};
    qa   = a;
    qb   = b;
    r    = '0;
    case (f)
      6'b011000: r = sa * sb64;
      6'b011001: r = {32'd0, a} * {32'd0, b};
      6'b011010: begin
        if (b == 32'd0)                                   r = {a, 32'hFFFF_FFFF};
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = {32'd0, a};
        else begin
          r[31:0]  = qa / qb;
          r[63:32] = qa % qb;
        end
      end
      6'b011011: begin
        if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
        else begin
          r[31:0]  = a / b;
          r[63:32] = a % b;
        end
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t        e;
    int          cyc;
    logic [5:0]  rf;
    logic [31:0] ra;
    logic [31:0] rb;

    // Reset state, with a decodable instruction present.
    valid_i  = 1'b1;
    alu_op_i = 2'b00;
    #3;
    chk("rst_ctrl",  64'(alu_ctrl_o), 64'hF);
    chk("rst_hi",    64'(hi_o),       64'h0);
    chk("rst_lo",    64'(lo_o),       64'h0);
    chk("rst_busy",  64'(md_busy_o),  64'h0);
    chk("rst_stall", 64'(stall_o),    64'h0);
    tick();
    tick();
    rst_n   = 1'b1;
    valid_i = 1'b0;
    tick();

    // Decode table; flush keeps anything from committing.
    flush_i = 1'b1;
    for (int i = 0; i < 18; i++) begin
      valid_i  = dec_tbl[i][12];
      alu_op_i = dec_tbl[i][11:10];
      funct_i  = dec_tbl[i][9:4];
      #1;
      chk($sformatf("decode_%0d", i), 64'(alu_ctrl_o), 64'(dec_tbl[i][3:0]));
    end
    valid_i = 1'b0;
    flush_i = 1'b0;
    tick();
    chk("decode_no_side_effect_busy", 64'(md_busy_o), 64'h0);

    // Directed MD operations, issued back-to-back.
    run_md("mult_m3x7",  6'b011000, 32'hFFFF_FFFD, 32'd7,         64'hFFFF_FFFF_FFFF_FFEB);
    run_md("multu_m3x7", 6'b011001, 32'hFFFF_FFFD, 32'd7,         64'h0000_0006_FFFF_FFEB);
    run_md("div_m7d2",   6'b011010, 32'hFFFF_FFF9, 32'd2,         64'hFFFF_FFFF_FFFF_FFFD);
    run_md("divu_7d0",   6'b011011, 32'd7,         32'd0,         64'h0000_0007_FFFF_FFFF);
    run_md("div_min_m1", 6'b011010, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000);
    run_md("div_m5d0",   6'b011010, 32'hFFFF_FFFB, 32'd0,         64'hFFFF_FFFB_FFFF_FFFF);
    run_md("div_100dm7", 6'b011010, 32'd100,       32'hFFFF_FFF9, 64'h0000_0002_FFFF_FFF2);

    // Pseudo-random operands checked against the reference model.
    for (int i = 0; i < 4; i++) begin
      rf = 6'b011000 | 6'(i);
      ra = $urandom;
      rb = (i >= 2) ? ($urandom >> ($urandom_range(0, 28))) | 32'd1 : $urandom;
      run_md($sformatf("rand_%0d", i), rf, ra, rb, md_model(rf, ra, rb));
    end

    // mflo arriving mid-multiply stalls until the product is in LO.
    e.tag  = "mflo_stall";
    e.hilo = md_model(6'b011000, 32'h0001_2345, 32'h0000_0100);
    sb.push_back(e);
    issue(6'b011000, 32'h0001_2345, 32'h0000_0100);
    repeat (4) tick();
    valid_i  = 1'b1;
    alu_op_i = 2'b10;
    funct_i  = 6'b010010;
    #1;
    cyc = 0;
    while (md_busy_o === 1'b1 && cyc < 200) begin
      chk("mflo_stall_high", 64'(stall_o), 64'h1);
      tick();
      cyc++;
    end
    chk("mflo_stall_cycles", 64'(cyc), 64'd29);
    chk("mflo_stall_low", 64'(stall_o), 64'h0);
    chk("mflo_ctrl", 64'(alu_ctrl_o), 64'h9);
    e = sb.pop_front();
    chk("mflo_lo", 64'(lo_o), 64'(e.hilo[31:0]));
    chk("mflo_hi", 64'(hi_o), 64'(e.hilo[63:32]));
    valid_i = 1'b0;
    tick();

    // mthi/mtlo preset, then flush mid-multiply.
    valid_i  = 1'b1;
    alu_op_i = 2'b10;
    funct_i  = 6'b010001;
    rs_i     = 32'h1234;
    tick();
    funct_i  = 6'b010011;
    rs_i     = 32'h5678;
    tick();
    valid_i  = 1'b0;
    chk("mthi", 64'(hi_o), 64'h1234);
    chk("mtlo", 64'(lo_o), 64'h5678);
    issue(6'b011000, 32'd3, 32'd5);
    repeat (9) tick();
    chk("flush_pre_busy", 64'(md_busy_o), 64'h1);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    chk("flush_busy", 64'(md_busy_o), 64'h0);
    repeat (30) tick();
    chk("flush_hi", 64'(hi_o), 64'h1234);
    chk("flush_lo", 64'(lo_o), 64'h5678);

    // Flush and accept in the same cycle: nothing starts.
    flush_i = 1'b1;
    issue(6'b011000, 32'd3, 32'd5);
    flush_i = 1'b0;
    chk("flush_accept_busy", 64'(md_busy_o), 64'h0);
    repeat (34) tick();
    chk("flush_accept_hi", 64'(hi_o), 64'h1234);
    chk("flush_accept_lo", 64'(lo_o), 64'h5678);

    // Asynchronous reset in the middle of a divide.
    issue(6'b011010, 32'd100, 32'd7);
    repeat (11) tick();
    chk("pre_rst_busy", 64'(md_busy_o), 64'h1);
    valid_i  = 1'b1;
    alu_op_i = 2'b00;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 64'(md_busy_o),  64'h0);
    chk("mid_rst_hi",   64'(hi_o),       64'h0);
    chk("mid_rst_lo",   64'(lo_o),       64'h0);
    chk("mid_rst_ctrl", 64'(alu_ctrl_o), 64'hF);
    tick();
    rst_n = 1'b1;
    #1;
    chk("post_rst_ctrl", 64'(alu_ctrl_o), 64'h2);
    valid_i = 1'b0;
    tick();
    chk("post_rst_busy", 64'(md_busy_o), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
